wgt_loader: RTL and testbench

WGT_LOADER -- requirements
Module: wgt_loader

---
 rtl/wgt_loader.sv | 95 +++++++++
 tb/tb_wgt_loader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/wgt_loader.sv
// Weight loader: streams TAPS-weight groups from memory into a shift buffer
// and holds each group until the consumer acknowledges it.
module wgt_loader #(
  parameter int ADDR_W = 10,
  parameter int TAPS   = 4,
  parameter int GRP_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [GRP_W-1:0]  num_grp,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic signed [7:0] mem_rdata,
  output logic              wgt_read,
  output logic signed [7:0] wgt_input,
  output logic              grp_valid,
  input  logic              grp_ack,
  output logic              busy,
  output logic              done
);

  localparam int CW = (TAPS > 1) ? $clog2(TAPS) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] DRAIN = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] FIN   = 3'd4;

  logic [2:0]        state;
  logic [ADDR_W-1:0] cur;
  logic [GRP_W-1:0]  rem;
  logic [CW-1:0]     cnt;
  logic              rd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cur   <= '0;
      rem   <= '0;
      cnt   <= '0;
      rd_q  <= 1'b0;
    end else begin
      // memory data returns one cycle after the strobe
      rd_q <= (state == FETCH);
      unique case (state)
        IDLE: begin
          if (start) begin
            if (num_grp != '0) begin
              cur   <= base_addr;
              rem   <= num_grp;
              cnt   <= '0;
              state <= FETCH;
            end else begin
              state <= FIN;
            end
          end
        end
        FETCH: begin
          if (cnt == CW'(TAPS - 1)) begin
            cnt   <= '0;
            state <= DRAIN;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DRAIN: state <= HOLD;
        HOLD: begin
          if (grp_ack) begin
            if (rem > GRP_W'(1)) begin
              rem   <= rem - GRP_W'(1);
              cur   <= cur + ADDR_W'(TAPS);
              state <= FETCH;
            end else begin
              state <= FIN;
            end
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_rd_en = (state == FETCH);
  assign mem_addr  = mem_rd_en ? cur + ADDR_W'(cnt) : '0;
  assign wgt_read  = rd_q;
  assign wgt_input = rd_q ? mem_rdata : 8'sd0;
  assign grp_valid = (state == HOLD);
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);

endmodule

// File: tb/tb_wgt_loader.sv
// Bench for wgt_loader: table and random transfers checked against a
// stream model of addresses, weights and buffer contents.
module tb_wgt_loader;

  localparam int TAPS = 4;
  localparam int AW   = 10;
  localparam int AMSK = (1 << AW) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [AW-1:0]     base_addr = '0;
  logic [7:0]        num_grp = '0;
  logic              mem_rd_en;
  logic [AW-1:0]     mem_addr;
  logic signed [7:0] mem_rdata = '0;
  logic              wgt_read;
  logic signed [7:0] wgt_input;
  logic              grp_valid;
  logic              grp_ack = 1'b0;
  logic              busy;
  logic              done;

  wgt_loader #(.ADDR_W(AW), .TAPS(TAPS), .GRP_W(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .base_addr(base_addr), .num_grp(num_grp),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .wgt_read(wgt_read),
    .wgt_input(wgt_input), .grp_valid(grp_valid),
    .grp_ack(grp_ack), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic signed [7:0] mem [1 << AW];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: captures the observable stream and a model shift buffer.
  bit mon = 0;
  bit gv_q = 0;
  int q_addr[$];
  int q_wgt[$];
  int snap[$];
  int n_done, n_busy;
  logic signed [7:0] tap [TAPS];

  always @(negedge clk) begin
    if (mon) begin
      if (mem_rd_en) q_addr.push_back(int'(mem_addr));
      else chk("addr_zero_idle", int'(mem_addr), 0);
      if (wgt_read) begin
        q_wgt.push_back(int'(wgt_input));
        for (int i = TAPS - 1; i > 0; i--) tap[i] = tap[i-1];
        tap[0] = wgt_input;
      end else begin
        chk("wgt_zero_idle", int'(wgt_input), 0);
      end
      if (grp_valid) chk("no_shift_in_hold", int'(wgt_read), 0);
      if (grp_valid && !gv_q)
        for (int i = 0; i < TAPS; i++) snap.push_back(int'(tap[i]));
      gv_q = grp_valid;
      if (done) n_done++;
      if (busy) n_busy++;
    end
  end

  task automatic run(input int base, input int num, input int dly,
                     input bit glitch, input int exp_reads);
    int w;
    q_addr.delete(); q_wgt.delete(); snap.delete();
    n_done = 0; n_busy = 0; gv_q = 0;
    for (int i = 0; i < TAPS; i++) tap[i] = '0;
    @(negedge clk);
    mon = 1;
    base_addr = AW'(base);
    num_grp = 8'(num);
    start = 1'b1;
    for (int g = 0; g < num; g++) begin
      w = 0;
      while (!grp_valid && w < 40) begin
        @(negedge clk);
        w++;
        start = glitch && g == 0 && w == 2;
        grp_ack = start;
        if (start) begin
          base_addr = AW'(base ^ 'h155);
          num_grp = 8'(num + 7);
        end
      end
      if (g == 0) chk("first_valid_latency", w, TAPS + 2);
      if (!grp_valid) begin
        chk("valid_timeout", 0, 1);
        break;
      end
      repeat (dly) begin
        @(negedge clk);
        chk("valid_held", int'(grp_valid), 1);
      end
      grp_ack = 1'b1;
      @(negedge clk);
      grp_ack = 1'b0;
      chk("valid_drop", int'(grp_valid), 0);
      chk("done_after_ack", int'(done), int'(g == num - 1));
    end
    if (num == 0) begin
      @(negedge clk);
      start = 1'b0;
      chk("done_zero_grp", int'(done), 1);
    end
    w = 0;
    while (busy && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("return_idle", int'(busy), 0);
    repeat (2) @(negedge clk);
    mon = 0;
    chk("n_reads", q_addr.size(), exp_reads);
    chk("n_wgt", q_wgt.size(), 4 * num);
    chk("n_snap", snap.size(), 4 * num);
    chk("n_done", n_done, 1);
    if (num == 0) chk("busy_cycles", n_busy, 1);
    for (int i = 0; i < q_addr.size() && i < 4 * num; i++)
      chk("rd_addr", q_addr[i], (base + i) & AMSK);
    for (int i = 0; i < q_wgt.size() && i < 4 * num; i++)
      chk("wgt_val", q_wgt[i], int'(mem[(base + i) & AMSK]));
    for (int k = 0; k < snap.size() && k < 4 * num; k++) begin
      int g = k / TAPS;
      int j = k % TAPS;
      chk("tap_val", snap[k],
          int'(mem[(base + g * TAPS + TAPS - 1 - j) & AMSK]));
    end
  endtask

  typedef struct {
    int base;
    int num;
    int dly;
    bit glitch;
    int exp_reads;
  } vec_t;

  vec_t tbl [6];

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"}, int'(mem_rd_en), 0);
    chk({tag, "_addr"}, int'(mem_addr), 0);
    chk({tag, "_wgt_read"}, int'(wgt_read), 0);
    chk({tag, "_wgt_input"}, int'(wgt_input), 0);
    chk({tag, "_grp_valid"}, int'(grp_valid), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    int stray;
    tbl[0] = '{'h010, 1, 0, 1'b0, 4};
    tbl[1] = '{'h010, 3, 5, 1'b0, 12};
    tbl[2] = '{'h3FE, 1, 0, 1'b0, 4};
    tbl[3] = '{'h000, 0, 0, 1'b0, 0};
    tbl[4] = '{'h100, 2, 1, 1'b1, 8};
    tbl[5] = '{'h3FC, 2, 2, 1'b0, 8};

    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);
    mem['h010] = 8'sd1;
    mem['h011] = -8'sd2;
    mem['h012] = 8'sd3;
    mem['h013] = -8'sd4;

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    for (int t = 0; t < 6; t++)
      run(tbl[t].base, tbl[t].num, tbl[t].dly, tbl[t].glitch,
          tbl[t].exp_reads);

    // Abort in the second FETCH cycle, then confirm a clean restart.
    @(negedge clk);
    base_addr = AW'('h020);
    num_grp = 8'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("abort_fetch1", int'(mem_rd_en), 1);
    @(negedge clk);
    chk("abort_fetch2", int'(mem_rd_en), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("abort");
    stray = 0;
    repeat (10) begin
      @(negedge clk);
      if (wgt_read || mem_rd_en) stray++;
    end
    chk("abort_no_reads", stray, 0);
    run('h020, 2, 0, 1'b0, 8);

    for (int r = 0; r < 8; r++) begin
      int n = int'($urandom_range(0, 3));
      run(int'($urandom_range(0, AMSK)), n,
          int'($urandom_range(0, 4)), 1'($urandom), 4 * n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
